// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// grant encoding, bus widths, the default starvation limit and the
// registered memory command payload.
package mem_pkg;

   localparam int unsigned ADR_W            = 30;
   localparam int unsigned DAT_W            = 32;
   localparam int unsigned BE_W             = 4;
   localparam int unsigned STARVE_W         = 2;
   localparam int unsigned STARVE_LIMIT_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2,
      GNT_WB   = 2'd3
   } gnt_t;

   // One memory transaction as presented on the mem* outputs.
   typedef struct packed {
      logic             rwb;
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] wdata;
      logic [BE_W-1:0]  byteen;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection.
// Ports:
//   i_ireq, i_dreq, i_wbreq : pending requests
//   i_starve                : instruction side has hit its starvation limit
//   o_gnt_c                 : winning requester (gnt_t encoding), GNT_NONE if idle
module mem_arb_pick
   import mem_pkg::*;
(
   input  logic       i_ireq,
   input  logic       i_dreq,
   input  logic       i_wbreq,
   input  logic       i_starve,
   output logic [1:0] o_gnt_c
);

   // A starved icache jumps the queue; otherwise writes drain before reads
   // so no read can overtake a queued write.
   always_comb begin
      o_gnt_c = GNT_NONE;
      if (i_starve && i_ireq) begin
         o_gnt_c = GNT_I;
      end else if (i_wbreq) begin
         o_gnt_c = GNT_WB;
      end else if (i_dreq) begin
         o_gnt_c = GNT_D;
      end else if (i_ireq) begin
         o_gnt_c = GNT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache refill, dcache refill and write-buffer drain onto a
// single memory port: IDLE -> BUSY (memen held until memdone) -> DONE (ack).
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   ireq/iadr/iack                 : icache read request, address, ack pulse
//   dreq/dadr/dack                 : dcache read request, address, ack pulse
//   wbreq/wbadr/wbdata/wbbyteen    : write-buffer request and payload
//   wback                          : write accepted pulse
//   rdata                          : read data, valid with iack/dack
//   memadr/memwdata/membyteen/memrwb/memen : registered memory command
//   memrdata/memdone               : memory response
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             ireq,
   input  logic [ADR_W-1:0] iadr,
   output logic             iack,
   input  logic             dreq,
   input  logic [ADR_W-1:0] dadr,
   output logic             dack,
   input  logic             wbreq,
   input  logic [ADR_W-1:0] wbadr,
   input  logic [DAT_W-1:0] wbdata,
   input  logic [BE_W-1:0]  wbbyteen,
   output logic             wback,
   output logic [DAT_W-1:0] rdata,
   output logic [ADR_W-1:0] memadr,
   output logic [DAT_W-1:0] memwdata,
   output logic [BE_W-1:0]  membyteen,
   input  logic [DAT_W-1:0] memrdata,
   output logic             memrwb,
   output logic             memen,
   input  logic             memdone
);

   // Counter is STARVE_W bits wide, so the limit must fit in it.
   localparam logic [STARVE_W-1:0] LP_STARVE_LIMIT = STARVE_W'(STARVE_LIMIT);

   state_t              r_state;
   state_t              w_state_nxt;
   gnt_t                r_gnt;
   gnt_t                w_gnt;
   logic [1:0]          w_gnt_raw;
   logic [STARVE_W-1:0] r_starve_cnt;
   mem_cmd_t            r_cmd;
   mem_cmd_t            w_win_cmd;
   logic                r_memen;
   logic                r_iack;
   logic                r_dack;
   logic                r_wback;
   logic [DAT_W-1:0]    r_rdata;
   logic                w_any_req;
   logic                w_starve;
   logic                w_grant;
   logic                w_finish;

   assign w_any_req = ireq | dreq | wbreq;
   assign w_starve  = (r_starve_cnt == LP_STARVE_LIMIT);

   mem_arb_pick u_pick (
      .i_ireq   (ireq),
      .i_dreq   (dreq),
      .i_wbreq  (wbreq),
      .i_starve (w_starve),
      .o_gnt_c  (w_gnt_raw)
   );

   assign w_gnt = gnt_t'(w_gnt_raw);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus grant/finish strobes; arbitration happens only in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_finish    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = ST_BUSY;
               w_grant     = 1'b1;
            end
         end
         ST_BUSY: begin
            if (memdone) begin
               w_state_nxt = ST_DONE;
               w_finish    = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Command for the current winner; reads carry full byte enables and zero data.
   always_comb begin
      w_win_cmd        = '0;
      w_win_cmd.rwb    = 1'b1;
      w_win_cmd.byteen = '1;
      case (w_gnt)
         GNT_WB: begin
            w_win_cmd.rwb    = 1'b0;
            w_win_cmd.adr    = wbadr;
            w_win_cmd.wdata  = wbdata;
            w_win_cmd.byteen = wbbyteen;
         end
         GNT_D:   w_win_cmd.adr = dadr;
         GNT_I:   w_win_cmd.adr = iadr;
         default: ;
      endcase
   end

   // Memory command, read data and ack pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd   <= '{rwb: 1'b1, adr: '0, wdata: '0, byteen: '0};
         r_gnt   <= GNT_NONE;
         r_memen <= 1'b0;
         r_iack  <= 1'b0;
         r_dack  <= 1'b0;
         r_wback <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_iack  <= 1'b0;
         r_dack  <= 1'b0;
         r_wback <= 1'b0;
         if (w_grant) begin
            r_cmd   <= w_win_cmd;
            r_gnt   <= w_gnt;
            r_memen <= 1'b1;
         end
         if (w_finish) begin
            r_memen <= 1'b0;
            if (r_cmd.rwb) begin
               r_rdata <= memrdata;
            end
            r_iack  <= (r_gnt == GNT_I);
            r_dack  <= (r_gnt == GNT_D);
            r_wback <= (r_gnt == GNT_WB);
         end
      end
   end

   // Counts consecutive non-instruction grants while ireq waits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if (!ireq) begin
         r_starve_cnt <= '0;
      end else if (w_grant) begin
         if (w_gnt == GNT_I) begin
            r_starve_cnt <= '0;
         end else if (r_starve_cnt != '1) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
         end
      end
   end

   assign memen     = r_memen;
   assign memrwb    = r_cmd.rwb;
   assign memadr    = r_cmd.adr;
   assign memwdata  = r_cmd.wdata;
   assign membyteen = r_cmd.byteen;
   assign rdata     = r_rdata;
   assign iack      = r_iack;
   assign dack      = r_dack;
   assign wback     = r_wback;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq, dreq, wbreq;
   logic [29:0] iadr, dadr, wbadr;
   logic [31:0] wbdata;
   logic [3:0]  wbbyteen;
   logic        iack, dack, wback;
   logic [31:0] rdata;
   logic [29:0] memadr;
   logic [31:0] memwdata;
   logic [3:0]  membyteen;
   logic [31:0] memrdata;
   logic        memrwb, memen, memdone;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iadr(iadr), .iack(iack),
      .dreq(dreq), .dadr(dadr), .dack(dack),
      .wbreq(wbreq), .wbadr(wbadr), .wbdata(wbdata), .wbbyteen(wbbyteen), .wback(wback),
      .rdata(rdata), .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen),
      .memrdata(memrdata), .memrwb(memrwb), .memen(memen), .memdone(memdone)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Table vectors: one request mix from reset, memdone high throughout.
   typedef struct {
      logic        i, d, wb;
      logic [29:0] exp_adr;
      logic        exp_rwb;
      logic [2:0]  exp_ack;   // {iack, dack, wback}
   } vec_t;
   vec_t vt[8];

   // Reference model state for the randomized phase.
   logic [31:0] mem_m [8];
   int          cnt_m, own, win, others;
   logic [29:0] own_adr;
   logic        own_rwb;
   logic [3:0]  own_be;
   logic [31:0] own_wd, t;
   bit          in_done, drop_i, drop_d, drop_wb, got;
   logic        e_i, e_d, e_wb, e_done, e_memen;
   logic [2:0]  acks, exp_acks;
   logic [29:0] snap_adr;

   initial begin
      reset = 1'b1; ireq = 0; dreq = 0; wbreq = 0;
      iadr = '0; dadr = '0; wbadr = '0; wbdata = '0; wbbyteen = '0;
      memrdata = '0; memdone = 0;
      tick(); tick();
      // Reset values
      chk("rst_memen", 32'(memen), 0);
      chk("rst_memrwb", 32'(memrwb), 1);
      chk("rst_memadr", 32'(memadr), 0);
      chk("rst_memwdata", memwdata, 0);
      chk("rst_membyteen", 32'(membyteen), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_acks", 32'({iack, dack, wback}), 0);
      reset = 1'b0;

      // ---------------- table-driven single grants ----------------
      vt[0] = '{0, 0, 0, 30'h000, 1'b1, 3'b000};
      vt[1] = '{1, 0, 0, 30'h100, 1'b1, 3'b100};
      vt[2] = '{0, 1, 0, 30'h200, 1'b1, 3'b010};
      vt[3] = '{0, 0, 1, 30'h300, 1'b0, 3'b001};
      vt[4] = '{1, 1, 0, 30'h200, 1'b1, 3'b010};
      vt[5] = '{1, 0, 1, 30'h300, 1'b0, 3'b001};
      vt[6] = '{0, 1, 1, 30'h300, 1'b0, 3'b001};
      vt[7] = '{1, 1, 1, 30'h300, 1'b0, 3'b001};
      for (int k = 0; k < 8; k++) begin
         do_reset();
         iadr = 30'h100; dadr = 30'h200; wbadr = 30'h300;
         wbdata = 32'h1234_5678; wbbyteen = 4'b0011;
         memrdata = 32'hCAFE_0000 + 32'(k);
         memdone = 1'b1;
         ireq = vt[k].i; dreq = vt[k].d; wbreq = vt[k].wb;
         tick();
         if (vt[k].exp_ack == 3'b000) begin
            chk("vec_idle_memen", 32'(memen), 0);
            tick();
            chk("vec_idle_memen2", 32'(memen), 0);
            chk("vec_idle_acks", 32'({iack, dack, wback}), 0);
         end else begin
            chk("vec_memen", 32'(memen), 1);
            chk("vec_memadr", 32'(memadr), 32'(vt[k].exp_adr));
            chk("vec_memrwb", 32'(memrwb), 32'(vt[k].exp_rwb));
            chk("vec_byteen", 32'(membyteen), vt[k].exp_rwb ? 32'hF : 32'h3);
            chk("vec_wdata", memwdata, vt[k].exp_rwb ? 32'h0 : 32'h1234_5678);
            chk("vec_acks_busy", 32'({iack, dack, wback}), 0);
            tick();
            chk("vec_memen_done", 32'(memen), 0);
            chk("vec_acks", 32'({iack, dack, wback}), 32'(vt[k].exp_ack));
            if (vt[k].exp_rwb) chk("vec_rdata", rdata, 32'hCAFE_0000 + 32'(k));
         end
         ireq = 0; dreq = 0; wbreq = 0;
      end

      // ---------------- single icache read, memdone stuck high ----------------
      do_reset();
      memdone = 1; memrdata = 32'hBEAD_BEEF; iadr = 30'h0AD; ireq = 1;
      tick();
      chk("i_memen", 32'(memen), 1);
      chk("i_memrwb", 32'(memrwb), 1);
      chk("i_memadr", 32'(memadr), 32'h0AD);
      chk("i_iack_early", 32'(iack), 0);
      tick();
      chk("i_memen_1cyc", 32'(memen), 0);
      chk("i_iack", 32'(iack), 1);
      chk("i_rdata", rdata, 32'hBEAD_BEEF);
      tick();
      ireq = 0;
      chk("i_iack_pulse", 32'(iack), 0);
      tick();
      chk("i_no_regrant", 32'(memen), 0);

      // ---------------- write then read to same address ----------------
      do_reset();
      memdone = 1; memrdata = 32'h0000_5E5E;
      wbadr = 30'h10; wbdata = 32'hDEAD_BEEF; wbbyteen = 4'b0101; wbreq = 1;
      dadr = 30'h10; dreq = 1;
      tick();
      chk("wr_memen", 32'(memen), 1);
      chk("wr_memrwb", 32'(memrwb), 0);
      chk("wr_memadr", 32'(memadr), 32'h10);
      chk("wr_byteen", 32'(membyteen), 32'h5);
      chk("wr_wdata", memwdata, 32'hDEAD_BEEF);
      tick();
      chk("wr_wback", 32'(wback), 1);
      chk("wr_dack", 32'(dack), 0);
      tick();
      wbreq = 0;
      chk("wr_gap", 32'(memen), 0);
      tick();
      chk("rd_memen", 32'(memen), 1);
      chk("rd_memrwb", 32'(memrwb), 1);
      chk("rd_memadr", 32'(memadr), 32'h10);
      chk("rd_byteen", 32'(membyteen), 32'hF);
      chk("rd_wdata", memwdata, 0);
      tick();
      chk("rd_dack", 32'(dack), 1);
      chk("rd_wback", 32'(wback), 0);
      chk("rd_rdata", rdata, 32'h0000_5E5E);
      tick();
      dreq = 0;

      // ---------------- icache starvation ----------------
      do_reset();
      memdone = 1; iadr = 30'h55; dadr = 30'h66; wbadr = 30'h77; wbbyteen = 4'hF;
      ireq = 1; dreq = 1; wbreq = 1;
      others = 0; got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
         tick();
         if (!wbreq) wbreq = 1;
         if (!dreq) dreq = 1;
         if (wback) begin others++; wbreq = 0; end
         if (dack) begin others++; dreq = 0; end
         if (iack) got = 1;
      end
      chk("starve_iack_seen", 32'(got), 1);
      chk("starve_other_grants", 32'(others), 32'(LIMIT));
      tick();
      ireq = 0; dreq = 0; wbreq = 0;

      // ---------------- memdone held low in BUSY ----------------
      do_reset();
      memdone = 0; memrdata = 32'h1357_9BDF; dadr = 30'h2AA; dreq = 1;
      tick();
      chk("stall_memen0", 32'(memen), 1);
      snap_adr = 30'h2AA;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stall_memen", 32'(memen), 1);
         chk("stall_memadr", 32'(memadr), 32'(snap_adr));
         chk("stall_dack", 32'(dack), 0);
      end
      memdone = 1;
      tick();
      chk("stall_dack_end", 32'(dack), 1);
      chk("stall_memen_end", 32'(memen), 0);
      chk("stall_rdata", rdata, 32'h1357_9BDF);
      tick();
      dreq = 0;

      // ---------------- reset during BUSY ----------------
      do_reset();
      memdone = 0; wbadr = 30'h3C; wbdata = 32'hA5A5_0F0F; wbbyteen = 4'hF; wbreq = 1;
      tick();
      chk("rb_memen", 32'(memen), 1);
      tick();
      reset = 1; memdone = 1;
      tick();
      reset = 0;
      chk("rb_memen_rst", 32'(memen), 0);
      chk("rb_no_ack", 32'({iack, dack, wback}), 0);
      chk("rb_memrwb", 32'(memrwb), 1);
      chk("rb_memadr", 32'(memadr), 0);
      tick();
      chk("rb_regrant", 32'(memen), 1);
      chk("rb_regrant_adr", 32'(memadr), 32'h3C);
      chk("rb_regrant_noack", 32'(wback), 0);
      tick();
      chk("rb_wback", 32'(wback), 1);
      tick();
      wbreq = 0;

      // ---------------- randomized traffic vs transaction model ----------------
      do_reset();
      for (int a = 0; a < 8; a++) mem_m[a] = $urandom;
      cnt_m = 0; own = 0; in_done = 0; drop_i = 0; drop_d = 0; drop_wb = 0;
      own_adr = '0; own_rwb = 1; own_be = '0; own_wd = '0;
      memdone = 0; memrdata = mem_m[0];
      for (int cyc = 0; cyc < 3000; cyc++) begin
         e_i = ireq; e_d = dreq; e_wb = wbreq; e_done = memdone; e_memen = memen;
         tick();
         acks = {iack, dack, wback};
         chk("rnd_ack_vs_memen", 32'(memen & (|acks)), 0);
         chk("rnd_ack_multi", 32'($countones(acks) > 1), 0);
         if (e_memen) begin
            if (e_done) begin
               exp_acks = (own == 1) ? 3'b100 : (own == 2) ? 3'b010 : 3'b001;
               chk("rnd_done_memen", 32'(memen), 0);
               chk("rnd_done_ack", 32'(acks), 32'(exp_acks));
               if (own_rwb) begin
                  chk("rnd_rdata", rdata, mem_m[own_adr[2:0]]);
               end else begin
                  t = mem_m[own_adr[2:0]];
                  for (int b = 0; b < 4; b++)
                     if (own_be[b]) t[b*8 +: 8] = own_wd[b*8 +: 8];
                  mem_m[own_adr[2:0]] = t;
               end
               own = 0;
               in_done = 1;
            end else begin
               chk("rnd_busy_memen", 32'(memen), 1);
               chk("rnd_busy_adr", 32'(memadr), 32'(own_adr));
               chk("rnd_busy_rwb", 32'(memrwb), 32'(own_rwb));
               chk("rnd_busy_be", 32'(membyteen), 32'(own_be));
               chk("rnd_busy_wd", memwdata, own_wd);
               chk("rnd_busy_ack", 32'(acks), 0);
            end
            if (!e_i) cnt_m = 0;
         end else begin
            chk("rnd_idle_ack", 32'(acks), 0);
            if (!in_done && (e_i || e_d || e_wb)) begin
               if (e_i && cnt_m >= LIMIT) win = 1;
               else if (e_wb) win = 3;
               else if (e_d) win = 2;
               else win = 1;
               if (win == 3) begin
                  own_adr = wbadr; own_rwb = 0; own_be = wbbyteen; own_wd = wbdata;
               end else begin
                  own_adr = (win == 1) ? iadr : dadr; own_rwb = 1; own_be = 4'hF; own_wd = 0;
               end
               chk("rnd_grant_memen", 32'(memen), 1);
               chk("rnd_grant_adr", 32'(memadr), 32'(own_adr));
               chk("rnd_grant_rwb", 32'(memrwb), 32'(own_rwb));
               chk("rnd_grant_be", 32'(membyteen), 32'(own_be));
               chk("rnd_grant_wd", memwdata, own_wd);
               if (!e_i || win == 1) cnt_m = 0;
               else cnt_m++;
               own = win;
            end else begin
               chk("rnd_no_grant", 32'(memen), 0);
               if (!e_i) cnt_m = 0;
            end
            in_done = 0;
         end
         // requesters hold through DONE, drop for one edge, then may re-request
         if (drop_i) begin ireq = 0; drop_i = 0; end
         else if (iack) drop_i = 1;
         else if (!ireq && $urandom_range(0, 3) == 0) begin
            ireq = 1; iadr = 30'($urandom_range(0, 7));
         end
         if (drop_d) begin dreq = 0; drop_d = 0; end
         else if (dack) drop_d = 1;
         else if (!dreq && $urandom_range(0, 3) == 0) begin
            dreq = 1; dadr = 30'($urandom_range(0, 7));
         end
         if (drop_wb) begin wbreq = 0; drop_wb = 0; end
         else if (wback) drop_wb = 1;
         else if (!wbreq && $urandom_range(0, 3) == 0) begin
            wbreq = 1; wbadr = 30'($urandom_range(0, 7));
            wbdata = $urandom; wbbyteen = 4'($urandom_range(1, 15));
         end
         memdone = ($urandom_range(0, 2) != 0);
         memrdata = mem_m[memadr[2:0]];
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Single clock clk; reset is synchronous and active-high; all state changes only on posedge clk.
REQ-002 Parameter STARVE_LIMIT, default 3, is the number of consecutive non-instruction grants tolerated while ireq is pending.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 ireq  in  1  icache refill read request, level, held until iack.
REQ-006 iadr  in  30  icache word address.
REQ-007 iack  out  1  one-cycle pulse, icache read complete, rdata valid.
REQ-008 dreq  in  1  dcache refill read request, level, held until dack.
REQ-009 dadr  in  30  dcache word address.
REQ-010 dack  out  1  one-cycle pulse, dcache read complete, rdata valid.
REQ-011 wbreq  in  1  write buffer drain request, level, held until wback.
REQ-012 wbadr  in  30  write word address.
REQ-013 wbdata  in  32  write data.
REQ-014 wbbyteen  in  4  write byte enables.
REQ-015 wback  out  1  one-cycle pulse, write accepted by memory.
REQ-016 rdata  out  32  registered read data, valid only while iack or dack is high.
REQ-017 memadr / memwdata / membyteen  out  30/32/4  registered memory address, write data, byte enables.
REQ-018 memrdata  in  32  memory read data, sampled with memdone.
REQ-019 memrwb  out  1  1 = read, 0 = write.
REQ-020 memen  out  1  memory transaction strobe, held high until memdone sampled.
REQ-021 memdone  in  1  memory completion; honoured only in state BUSY.

Function
REQ-022 FSM states IDLE, BUSY, DONE; IDLE->BUSY on an edge where any request is high; BUSY->DONE on the first edge with memdone=1; DONE->IDLE unconditionally.
REQ-023 Arbitration only in IDLE; default priority wb > d > i, so a pending write always reaches memory before a later-granted read (no read bypasses a queued write).
REQ-024 Starvation counter (2 bits): increments on each wb or d grant while ireq=1; clears on an i grant or any edge with ireq=0; when it equals STARVE_LIMIT, i takes top priority for the next grant.
REQ-025 On grant, memadr/memrwb/membyteen/memwdata load from the winner (reads: membyteen=4'b1111, memwdata=0) and memen=1 in the cycle after the granting edge.
REQ-026 Memory outputs are held stable throughout BUSY; a memdone high before BUSY is ignored.
REQ-027 On the BUSY->DONE edge: memen<=0, rdata<=memrdata for reads, and exactly one ack for the granted requester goes high for exactly one cycle (DONE).
REQ-028 No arbitration in DONE; the requester deasserts its req on the edge ending DONE; minimum request-to-ack spacing is 2 cycles with memdone already high, and back-to-back grants are separated by 1 IDLE cycle.
REQ-029 Simultaneous requests produce one grant; losers stay pending without loss; no request is granted twice for one assertion.
REQ-030 memen and any ack are never high in the same cycle; at most one ack is high per cycle.

Reset
REQ-031 Reset outputs: memen=0, memrwb=1, memadr=0, memwdata=0, membyteen=0, rdata=0, iack=dack=wback=0; state IDLE; starvation counter 0.
REQ-032 Reset mid-BUSY abandons the transaction with no ack; requesters re-request after reset.

Structure
REQ-033 Shared package mem_pkg holds the state enum, the grant encoding (NONE, I, D, WB) and the STARVE_LIMIT default.
REQ-034 One combinational sub-module mem_arb_pick computes the grant from the requests and the starvation flag; the FSM, counter and registers stay in mem_arbiter.

Verification
REQ-035 Single ireq with iadr=0x0AD, memdone stuck high, memrdata=0xBEADBEEF -> memen high for 1 cycle, iack pulses with rdata=0xBEADBEEF, memrwb=1.
REQ-036 wbreq and dreq raised on the same edge (wbadr=dadr=0x10, wbdata=0xDEADBEEF) -> write issued first (memrwb=0, wbbyteen passed through), wback, then the read with dack.
REQ-037 ireq held while wbreq/dreq re-assert continuously -> iack occurs after at most 3 other grants.
REQ-038 memdone low for 5 cycles in BUSY -> memen and memadr stable all 5 cycles, ack only after memdone rises.
REQ-039 Reset asserted during BUSY -> next cycle memen=0, no ack, state IDLE; a re-request completes normally.
